// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: byte FIFO that paces stores into a busy-flag-less uart, one frame at a time.
// Optional: define UART_SCHED_STATS_EN to add drop_count / sent_count statistics outputs.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | no frame in flight; launches next cycle if FIFO non-empty
//   S_LAUNCH | strobe uart_wr_o with head byte, pop it, load frame timer
//   S_WAIT   | frame in flight; timer counts down to 0
module uart_tx_scheduler #(
    parameter int DEPTH        = 16,
    parameter int FRAME_CYCLES = 8680
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     stall_req,
    output logic                     uart_wr_o,
    output logic [7:0]               uart_dat_o,
    output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef UART_SCHED_STATS_EN
    output logic [15:0]              drop_count,
    output logic [31:0]              sent_count,
`endif
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FRAME_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic [CW-1:0]   r_frame_cnt;
    logic            r_uart_wr;
    logic [7:0]      r_uart_dat;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_stall;
    logic            w_launch_next;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (r_count != '0) w_next_state = S_LAUNCH;
            S_LAUNCH: w_next_state = S_WAIT;
            S_WAIT:   if (r_frame_cnt == '0) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // FSM: outputs and FIFO handshake
    always_comb begin
        w_full        = (r_count == (AW+1)'(DEPTH));
        w_pop         = (r_state == S_LAUNCH);
        w_push        = wr_en && (!w_full || w_pop);
        w_stall       = wr_en && w_full && !w_pop;
        w_launch_next = (w_next_state == S_LAUNCH);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    // The strobe is registered one cycle ahead so it coincides with the LAUNCH state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_frame_cnt <= '0;
            r_uart_wr   <= 1'b0;
            r_uart_dat  <= 8'h00;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_state == S_LAUNCH)
                r_frame_cnt <= CW'(FRAME_CYCLES - 1);
            else if (r_state == S_WAIT && r_frame_cnt != '0)
                r_frame_cnt <= r_frame_cnt - 1'b1;
            r_uart_wr <= w_launch_next;
            if (w_launch_next) r_uart_dat <= r_mem[r_rd_ptr];
        end
    end

`ifdef UART_SCHED_STATS_EN
    logic [15:0] r_drop_count;
    logic [31:0] r_sent_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
            r_sent_count <= '0;
        end else begin
            if (w_stall && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
            if (w_pop) r_sent_count <= r_sent_count + 1'b1;
        end
    end

    assign drop_count = r_drop_count;
    assign sent_count = r_sent_count;
`endif

    assign full       = w_full;
    assign stall_req  = w_stall;
    assign uart_wr_o  = r_uart_wr;
    assign uart_dat_o = r_uart_dat;
    assign fifo_count = r_count;
    assign idle       = (r_count == '0) && (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with DEPTH=4, FRAME_CYCLES=20.
// Define UART_SCHED_STATS_EN to also exercise the statistics counters.
module tb_uart_tx_scheduler;

    localparam int DEPTH        = 4;
    localparam int FRAME_CYCLES = 20;
    localparam int SPACING      = FRAME_CYCLES + 2;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        stall_req;
    logic        uart_wr_o;
    logic [7:0]  uart_dat_o;
    logic [2:0]  fifo_count;
    logic        idle;
`ifdef UART_SCHED_STATS_EN
    logic [15:0] drop_count;
    logic [31:0] sent_count;
`endif

    uart_tx_scheduler #(.DEPTH(DEPTH), .FRAME_CYCLES(FRAME_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .stall_req  (stall_req),
        .uart_wr_o  (uart_wr_o),
        .uart_dat_o (uart_dat_o),
        .fifo_count (fifo_count),
`ifdef UART_SCHED_STATS_EN
        .drop_count (drop_count),
        .sent_count (sent_count),
`endif
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_fail;
    int         cyc;
    int         n_strobe;
    int         s_cyc[$];
    logic [7:0] s_dat[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and strobes logged.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (uart_wr_o) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(uart_dat_o);
            n_strobe++;
        end
    endtask

    task automatic wr_step(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic restart_log();
        cyc = 0;
        s_cyc.delete();
        s_dat.delete();
    endtask

    logic [7:0] exp3 [6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_strobe = 0;
        cyc      = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        exp3[0] = 8'h01; exp3[1] = 8'h02; exp3[2] = 8'h03;
        exp3[3] = 8'h04; exp3[4] = 8'h05; exp3[5] = 8'h00;

        repeat (3) step();
        chk("rst_full",  full,       0);
        chk("rst_stall", stall_req,  0);
        chk("rst_wr",    uart_wr_o,  0);
        chk("rst_dat",   uart_dat_o, 8'h00);
        chk("rst_count", fifo_count, 0);
        chk("rst_idle",  idle,       1);
        rst = 1'b0;

        // single byte: strobe in cycle 2 only, idle again from cycle 23
        restart_log();
        wr_step(8'h41);
        chk("t1_count_c1", fifo_count, 1);
        chk("t1_wr_c1",    uart_wr_o,  0);
        step();
        chk("t1_wr_c2",    uart_wr_o,  1);
        chk("t1_dat_c2",   uart_dat_o, 8'h41);
        step();
        chk("t1_wr_c3",    uart_wr_o,  0);
        chk("t1_dat_hold", uart_dat_o, 8'h41);
        while (cyc < 22) step();
        chk("t1_idle_c22", idle, 0);
        step();
        chk("t1_idle_c23", idle, 1);
        chk("t1_nstrobe",  s_cyc.size(), 1);
        chk("t1_strobe_cyc", s_cyc[0], 2);

        // three bytes: launches every FRAME_CYCLES+2 cycles, in order
        restart_log();
        wr_step(8'h31);
        chk("t2_count_c1", fifo_count, 1);
        wr_step(8'h32);
        chk("t2_count_c2", fifo_count, 2);
        wr_step(8'h33);
        chk("t2_count_c3", fifo_count, 2);
        while (cyc < 70) step();
        chk("t2_nstrobe", s_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_cyc", s_cyc[i], 2 + SPACING * i);
            chk("t2_dat", s_dat[i], 8'h31 + i);
        end
        chk("t2_idle", idle, 1);

        // overflow: 06 dropped with stall; then a write during LAUNCH while full is accepted
        restart_log();
        wr_step(8'h01);
        wr_step(8'h02);
        wr_step(8'h03);
        wr_step(8'h04);
        wr_en = 1'b1; wr_data = 8'h05; #1;
        chk("t3_stall_c4", stall_req, 0);
        step();
        wr_en = 1'b1; wr_data = 8'h06; #1;
        chk("t3_full_c5",  full,      1);
        chk("t3_stall_c5", stall_req, 1);
        step();
        wr_en = 1'b0;
        chk("t3_count_c6", fifo_count, 4);
        while (cyc < 24) step();
        chk("t5_wr_c24",   uart_wr_o, 1);
        chk("t5_full_c24", full,      1);
        wr_en = 1'b1; wr_data = 8'h00; #1;
        chk("t5_stall_c24", stall_req, 0);
        step();
        wr_en = 1'b0;
        chk("t5_count_c25", fifo_count, 4);
        while (cyc < 134) step();
        chk("t3_idle",    idle, 1);
        chk("t3_nstrobe", s_cyc.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t3_cyc", s_cyc[i], 2 + SPACING * i);
            chk("t3_dat", s_dat[i], exp3[i]);
        end
`ifdef UART_SCHED_STATS_EN
        chk("t3_drop_count", drop_count, 1);
        chk("t3_sent_count", sent_count, 10);
`endif

        // reset during WAIT with three bytes queued
        restart_log();
        wr_step(8'hA1);
        wr_step(8'hA2);
        wr_step(8'hA3);
        wr_step(8'hA4);
        while (cyc < 10) step();
        chk("t4_count_pre", fifo_count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_count", fifo_count, 0);
        chk("t4_idle",  idle,       1);
        chk("t4_wr",    uart_wr_o,  0);
        chk("t4_dat",   uart_dat_o, 8'h00);
        repeat (60) step();
        chk("t4_nstrobe", s_cyc.size(), 1);
        chk("t4_idle_end", idle, 1);

`ifdef UART_SCHED_STATS_EN
        // sustained overflow: drop counter saturates, sent counter tracks strobes
        rst = 1'b1;
        step();
        rst = 1'b0;
        restart_log();
        n_strobe = 0;
        chk("t6_drop_rst", drop_count, 0);
        chk("t6_sent_rst", sent_count, 0);
        wr_en = 1'b1; wr_data = 8'h55;
        repeat (72000) step();
        wr_en = 1'b0;
        chk("t6_drop_sat", drop_count, 16'hFFFF);
        repeat (200) step();
        chk("t6_idle", idle, 1);
        chk("t6_sent", sent_count, n_strobe);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
